// File: rtl/seq_alu_unit.sv
// Handshaked RV32 EX-stage ALU: integer, compare and branch ops, registered result and branch condition.
// Define SEQ_ALU_MDU_EN to compile in the iterative RV32M multiply/divide engine.
module seq_alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            bcond,
  output logic            illegal,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t          state;
  logic            fire;
  logic [SW-1:0]   shamt;
  logic            signed_lt;
  logic            unsigned_lt;
  logic [XLEN-1:0] alu_res;
  logic            alu_bcond;
  logic            alu_ill;

  assign in_ready    = (state == IDLE);
  assign fire        = in_valid && in_ready;
  assign shamt       = op_b[SW-1:0];
  assign signed_lt   = $signed(op_a) < $signed(op_b);
  assign unsigned_lt = op_a < op_b;

`ifdef SEQ_ALU_MDU_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              go_mul, go_div;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mc;
  logic [SW-1:0]     cnt;
  logic              neg_q, neg_r, sel_hi;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // prod doubles as {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mc} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, prod[XLEN-1:1]};
  assign mul_fix   = neg_q ? -mul_next : mul_next;
  assign div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mc};
  assign div_ok    = ~div_diff[XLEN];
  assign div_next  = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], prod[XLEN-2:0], div_ok};
  assign quo_fix   = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fix   = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
`endif

  function automatic logic [XLEN-1:0] zx(input logic b);
    return {{(XLEN-1){1'b0}}, b};
  endfunction

  always_comb begin
    alu_res   = '0;
    alu_bcond = 1'b0;
    alu_ill   = 1'b0;
`ifdef SEQ_ALU_MDU_EN
    go_mul = 1'b0;
    go_div = 1'b0;
    a_neg  = (funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11)) & op_a[XLEN-1];
    b_neg  = (funct3[2] ? ~funct3[0] : ~funct3[1]) & op_b[XLEN-1];
    mag_a  = a_neg ? -op_a : op_a;
    mag_b  = b_neg ? -op_b : op_b;
`endif
    case (opcode)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR: alu_res = op_a + op_b;
      OP_IMM, OP_REG: begin
        if (opcode == OP_REG && funct7 == 7'b0000001) begin
`ifdef SEQ_ALU_MDU_EN
          // zero divisor and signed overflow resolve immediately without iterating
          if (funct3[2]) begin
            if (op_b == '0)
              alu_res = funct3[1] ? op_a : '1;
            else if (!funct3[0] && op_a == MIN_NEG && op_b == '1)
              alu_res = funct3[1] ? '0 : op_a;
            else
              go_div = 1'b1;
          end else begin
            go_mul = 1'b1;
          end
`else
          alu_ill = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000: alu_res = (opcode == OP_REG && funct7 == 7'b0100000) ? op_a - op_b : op_a + op_b;
            3'b001: alu_res = op_a << shamt;
            3'b010: alu_res = zx(signed_lt);
            3'b011: alu_res = zx(unsigned_lt);
            3'b100: alu_res = op_a ^ op_b;
            3'b101: begin
              if (funct7[5]) alu_res = $signed(op_a) >>> shamt;
              else           alu_res = op_a >> shamt;
            end
            3'b110: alu_res = op_a | op_b;
            default: alu_res = op_a & op_b;
          endcase
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000: alu_bcond = (op_a == op_b);
          3'b001: alu_bcond = (op_a != op_b);
          3'b100: alu_bcond = signed_lt;
          3'b101: alu_bcond = ~signed_lt;
          3'b110: alu_bcond = unsigned_lt;
          3'b111: alu_bcond = ~unsigned_lt;
          default: alu_ill = 1'b1;
        endcase
        alu_res = zx(alu_bcond);
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // Single-cycle ops register straight from the decode; M-ops run XLEN iterations then publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      bcond     <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
`ifdef SEQ_ALU_MDU_EN
      prod   <= '0;
      mc     <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      sel_hi <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
`ifdef SEQ_ALU_MDU_EN
            if (go_mul || go_div) begin
              state  <= go_mul ? MUL : DIV;
              busy   <= 1'b1;
              cnt    <= '0;
              prod   <= {{XLEN{1'b0}}, go_mul ? mag_b : mag_a};
              mc     <= go_mul ? mag_a : mag_b;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              sel_hi <= go_mul ? (funct3[1:0] != 2'b00) : funct3[1];
            end else
`endif
            begin
              out_valid <= 1'b1;
              result    <= alu_res;
              bcond     <= alu_bcond;
              illegal   <= alu_ill;
            end
          end
        end
`ifdef SEQ_ALU_MDU_EN
        MUL, DIV: begin
          prod <= (state == MUL) ? mul_next : div_next;
          cnt  <= cnt + 1'b1;
          if (cnt == SW'(XLEN-1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            bcond     <= 1'b0;
            illegal   <= 1'b0;
            if (state == MUL) result <= sel_hi ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];
            else              result <= sel_hi ? rem_fix : quo_fix;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit: directed cases, random ops against a reference model,
// back-to-back stream and mid-operation reset. Follows SEQ_ALU_MDU_EN like the design.
`timescale 1ns/1ps
module tb_seq_alu_unit;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_BR    = 7'h63;

  typedef struct packed {
    logic [31:0] res;
    logic        bc;
    logic        ill;
    logic        multi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic [31:0] result;
  logic        bcond;
  logic        illegal;
  logic        busy;

  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] obsRes;
  logic        obsBc, obsIll;
  int          obsLat;

  seq_alu_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .result(result), .bcond(bcond), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference behaviour straight from the instruction semantics, using wide integer arithmetic
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          sh;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    e  = '0;
    sh = int'(b[4:0]);
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR: e.res = a + b;
      OP_IMM, OP_REG: begin
        if (op == OP_REG && f7 == 7'h01) begin
`ifdef SEQ_ALU_MDU_EN
          case (f3)
            3'd0: begin p = sa * sb; e.res = p[31:0];  e.multi = 1'b1; end
            3'd1: begin p = sa * sb; e.res = p[63:32]; e.multi = 1'b1; end
            3'd2: begin p = sa * ub; e.res = p[63:32]; e.multi = 1'b1; end
            3'd3: begin p = ua * ub; e.res = p[63:32]; e.multi = 1'b1; end
            3'd4: begin
              if (b == 32'd0) e.res = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
              else begin e.res = 32'(sa / sb); e.multi = 1'b1; end
            end
            3'd5: begin
              if (b == 32'd0) e.res = 32'hFFFF_FFFF;
              else begin e.res = a / b; e.multi = 1'b1; end
            end
            3'd6: begin
              if (b == 32'd0) e.res = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'd0;
              else begin e.res = 32'(sa % sb); e.multi = 1'b1; end
            end
            default: begin
              if (b == 32'd0) e.res = a;
              else begin e.res = a % b; e.multi = 1'b1; end
            end
          endcase
`else
          e.ill = 1'b1;
`endif
        end else begin
          case (f3)
            3'd0: e.res = (op == OP_REG && f7 == 7'h20) ? a - b : a + b;
            3'd1: e.res = a << sh;
            3'd2: e.res = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
            3'd4: e.res = a ^ b;
            3'd5: begin
              e.res = a >> sh;
              if (f7[5] && a[31]) e.res = e.res | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: e.res = a | b;
            default: e.res = a & b;
          endcase
        end
      end
      OP_BR: begin
        case (f3)
          3'd0: e.bc = (a == b);
          3'd1: e.bc = (a != b);
          3'd4: e.bc = (sa < sb);
          3'd5: e.bc = (sa >= sb);
          3'd6: e.bc = (a < b);
          3'd7: e.bc = (a >= b);
          default: e.ill = 1'b1;
        endcase
        e.res = {31'd0, e.bc};
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one op, waits (bounded) for its out_valid and records latency and outputs
  task automatic applyStimulus(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               input bit hold, input bit expectMulti);
    int leaks;
    leaks = 0;
    checkOutput({tag, " ready"}, 64'(in_ready), 64'd1);
    opcode = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    obsLat = 1;
    if (!hold) in_valid = 1'b0;
    while (!out_valid && obsLat < 60) begin
      if (in_ready || !busy) leaks++;
      @(posedge clk); #1;
      obsLat++;
    end
    in_valid = 1'b0;
    obsRes = result;
    obsBc  = bcond;
    obsIll = illegal;
    if (expectMulti) begin
      checkOutput({tag, " stall"}, 64'(leaks), 64'd0);
      checkOutput({tag, " done"}, 64'({in_ready, busy}), 64'b10);
    end
  endtask

  task automatic doOp(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input bit hold);
    exp_t e;
    e = model(op, f3, f7, a, b);
    applyStimulus(tag, op, f3, f7, a, b, hold, e.multi);
    checkOutput({tag, " lat"}, 64'(obsLat), e.multi ? 64'd33 : 64'd1);
    checkOutput({tag, " res"}, 64'(obsRes), 64'(e.res));
    checkOutput({tag, " illegal"}, 64'(obsIll), 64'(e.ill));
    if (op == OP_BR) checkOutput({tag, " bcond"}, 64'(obsBc), 64'(e.bc));
    @(posedge clk); #1;
    checkOutput({tag, " hold"}, 64'({out_valid, result}), {31'd0, 1'b0, e.res});
  endtask

  task automatic genOp(input bit singleOnly, output logic [6:0] op, output logic [2:0] f3,
                       output logic [6:0] f7, output logic [31:0] a, output logic [31:0] b);
    exp_t e;
    case ($urandom_range(0, 8))
      0: op = OP_LOAD;
      1: op = OP_STORE;
      2: op = OP_JAL;
      3: op = OP_JALR;
      4: op = OP_IMM;
      5, 6: op = OP_REG;
      7: op = OP_BR;
      default: op = 7'($urandom);
    endcase
    f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0: a = 32'h8000_0000;
      1: a = 32'hFFFF_FFFF;
      2: a = 32'd0;
      default: a = $urandom;
    endcase
    case ($urandom_range(0, 4))
      0: b = 32'hFFFF_FFFF;
      1: b = 32'd0;
      2: b = 32'($urandom_range(0, 40));
      default: b = $urandom;
    endcase
    e = model(op, f3, f7, a, b);
    if (singleOnly && e.multi) f7 = 7'h00;
  endtask

  task automatic runStream(input int n);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    exp_t        e;
    for (int i = 0; i < n; i++) begin
      genOp(1'b1, op, f3, f7, a, b);
      e = model(op, f3, f7, a, b);
      opcode = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("stream%0d valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("stream%0d res", i), 64'(result), 64'(e.res));
      checkOutput($sformatf("stream%0d illegal", i), 64'(illegal), 64'(e.ill));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("stream end", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          seen;

    reset = 1'b1; in_valid = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", 64'({out_valid, bcond, illegal, busy, result}), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    doOp("add", OP_REG, 3'd0, 7'h00, 32'd7, 32'd5, 1'b0);
    checkOutput("add const", 64'(obsRes), 64'd12);
    checkOutput("add lat", 64'(obsLat), 64'd1);
    doOp("sub", OP_REG, 3'd0, 7'h20, 32'd5, 32'd7, 1'b0);
    checkOutput("sub const", 64'(obsRes), 64'hFFFF_FFFE);
    doOp("addi", OP_IMM, 3'd0, 7'h20, 32'd7, 32'd5, 1'b0);
    checkOutput("addi const", 64'(obsRes), 64'd12);
    doOp("sra", OP_REG, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 1'b0);
    checkOutput("sra const", 64'(obsRes), 64'hF800_0000);
    doOp("srli", OP_IMM, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 1'b0);
    checkOutput("srli const", 64'(obsRes), 64'h0800_0000);
    doOp("sll33", OP_REG, 3'd1, 7'h00, 32'd3, 32'd33, 1'b0);
    checkOutput("sll33 const", 64'(obsRes), 64'd6);
    doOp("bltu", OP_BR, 3'd6, 7'h00, 32'd1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("bltu const", 64'(obsBc), 64'd1);
    doOp("blt", OP_BR, 3'd4, 7'h00, 32'd1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("blt const", 64'(obsBc), 64'd0);
    doOp("br010", OP_BR, 3'd2, 7'h00, 32'd1, 32'd2, 1'b0);
    checkOutput("br010 const", 64'(obsIll), 64'd1);
    doOp("op7f", 7'h7F, 3'd0, 7'h00, 32'd9, 32'd9, 1'b0);
    checkOutput("op7f const", 64'({obsIll, obsRes}), {31'd0, 1'b1, 32'd0});

`ifdef SEQ_ALU_MDU_EN
    doOp("mul", OP_REG, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd2, 1'b1);
    checkOutput("mul const", 64'(obsRes), 64'hFFFF_FFFE);
    checkOutput("mul lat33", 64'(obsLat), 64'd33);
    doOp("mulh", OP_REG, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'd2, 1'b1);
    checkOutput("mulh const", 64'(obsRes), 64'hFFFF_FFFF);
    doOp("mulhu", OP_REG, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checkOutput("mulhu const", 64'(obsRes), 64'd1);
    doOp("div", OP_REG, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("div const", 64'(obsRes), 64'hFFFF_FFFD);
    checkOutput("div lat33", 64'(obsLat), 64'd33);
    doOp("rem", OP_REG, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("rem const", 64'(obsRes), 64'hFFFF_FFFF);
    doOp("divu0", OP_REG, 3'd5, 7'h01, 32'd1234, 32'd0, 1'b0);
    checkOutput("divu0 const", 64'(obsRes), 64'hFFFF_FFFF);
    checkOutput("divu0 lat1", 64'(obsLat), 64'd1);
    doOp("divovf", OP_REG, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkOutput("divovf const", 64'(obsRes), 64'h8000_0000);
`else
    doOp("mul off", OP_REG, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checkOutput("mul off illegal", 64'(obsIll), 64'd1);
    checkOutput("mul off lat", 64'(obsLat), 64'd1);
    checkOutput("mul off busy", 64'(busy), 64'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      genOp(1'b0, op, f3, f7, a, b);
      doOp($sformatf("rnd%0d", i), op, f3, f7, a, b, 1'b0);
    end

    runStream(24);

`ifdef SEQ_ALU_MDU_EN
    opcode = OP_REG; funct3 = 3'd4; funct7 = 7'h01; op_a = 32'd1000; op_b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checkOutput("abort busy before", 64'(busy), 64'd1);
`endif
    reset = 1'b1;
    #1;
    checkOutput("abort outputs", 64'({busy, out_valid, illegal, bcond, result}), 64'd0);
    checkOutput("abort in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    checkOutput("abort quiet", 64'(seen), 64'd0);

    doOp("post-reset add", OP_REG, 3'd0, 7'h00, 32'd40, 32'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_alu_unit.md
# seq_alu_unit

Parametrised, handshaked ALU execution unit for the RV32 datapath: it decodes `opcode`/`funct3`/`funct7` internally and produces the registered result. It also produces the branch condition. It covers the full RV32I integer/compare/branch set and, optionally, the RV32M multiply/divide ops through an iterative multi-cycle engine. It sits in the EX stage of the multi-cycle core, between operand muxing and the write-back/PC-update logic.

## Interface
- `XLEN`, default 32: operand/result width. Must be a power of two, ≥ 8.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; equals (state == IDLE).
- `opcode`  in  7  instruction opcode, using the encodings in `opcodes.v`.
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7. For I-type this is imm[11:5].
- `op_a`, `op_b`  in  XLEN  operands (`op_b` is already the immediate for I/S/load/JALR).
- `out_valid`  out  1  one-cycle pulse; `result`/`bcond`/`illegal` are valid this cycle.
- `result`  out  XLEN  registered result.
- `bcond`  out  1  branch taken; meaningful only for BRANCH.
- `illegal`  out  1  unsupported encoding.
- `busy`  out  1  a multi-cycle op is in flight.

## Operation
- Transfer occurs when `in_valid && in_ready`. When `in_ready` = 0, `in_valid` is ignored. Operands and functs are captured at the transfer edge.
- States: IDLE, MUL, DIV.
  - IDLE stays in IDLE for single-cycle ops.
  - IDLE goes to MUL or DIV for M-ops.
  - MUL/DIV return to IDLE on the edge that asserts `out_valid`.
- ADD is selected for LOAD, STORE, JAL, JALR, and for ARITHMETIC_IMM with funct3 = 000 regardless of funct7.
- ARITHMETIC with funct3 = 000 is SUB if `funct7` = 0100000, otherwise ADD.
- Other funct3 values (both R and I forms):
  - 001 SLL
  - 010 SLT
  - 011 SLTU
  - 100 XOR
  - 101 SRL, or SRA if `funct7[5]`
  - 110 OR
  - 111 AND
- Shift amount is `op_b[$clog2(XLEN)-1:0]`.
- SLT/SLTU write result = {0…, flag}.
- BRANCH funct3 selects the comparison: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. For branches, result = {0…, bcond}. Branch funct3 values 010 and 011 are illegal.
- Illegal cases: any other opcode, or an illegal branch funct3. These complete in 1 cycle with `illegal` = 1 and result = 0.
- M-ops are ARITHMETIC with `funct7` = 0000001. funct3 selects: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- MUL path: radix-2 shift-add on the magnitudes, with a 2·XLEN product; the sign is applied on the final edge. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DIV path: restoring division on the magnitudes. The quotient sign is sign(a) XOR sign(b); the remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = `op_a`. Completes in 1 cycle without entering DIV.
- Signed overflow (`op_a` = 1000…0, `op_b` = all ones): quotient = `op_a`, remainder = 0. Completes in 1 cycle.

## Timing
- Reset values: `out_valid` 0, `result` 0, `bcond` 0, `illegal` 0, `busy` 0, state IDLE. `in_ready` is 1 once `reset` is low.
- Single-cycle ops: transfer at edge T, `out_valid` high for the cycle after T. Back-to-back transfers on every edge are supported, giving throughput 1/cycle.
- MUL/DIV iterative ops:
  - `busy` is high from edge T through edge T+XLEN, and `in_ready` is 0 over the same span.
  - `out_valid` is high in the cycle after edge T+XLEN, i.e. XLEN+1 cycles after transfer.
  - `in_ready` returns to 1 in that same cycle, so a new op may transfer on the following edge.
- `out_valid` has no backpressure. Outputs hold their last value until the next completion; only `out_valid` drops to 0.
- Reset asserted mid-operation aborts immediately (asynchronously). The aborted op never produces `out_valid`.

## Configuration
- `SEQ_ALU_MDU_EN` defined: the MUL/DIV states, the datapath and the M-op decode are compiled in.
- `SEQ_ALU_MDU_EN` undefined: funct7 = 0000001 on ARITHMETIC is illegal. It completes in 1 cycle with `illegal` = 1 and result = 0. `busy` is tied to 0.

## Test plan
- ADD, a=7, b=5 → `out_valid` 1 cycle after transfer, result 12. SUB (funct7 = 0100000), 5−7 → 0xFFFFFFFE. ADDI with funct7 = 0100000 → still ADD.
- SRA 0x80000000 by 4 → 0xF8000000. SRLI same → 0x08000000. SLL with `op_b` = 33 → shift by 1.
- BLTU a=1, b=0xFFFFFFFF → `bcond` 1. BLT same → 0. Branch funct3 = 010 → `illegal` 1. Opcode 0x7F → `illegal` 1, result 0.
- a=0xFFFFFFFF, b=2 (macro on):
  - MUL → 0xFFFFFFFE.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000001.
  - `out_valid` exactly 33 cycles after transfer; `in_ready` 0 in between; `in_valid` held high is ignored.
- Division cases (macro on):
  - DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF, each after 33 cycles.
  - DIVU x/0 → 0xFFFFFFFF after 1 cycle.
  - DIV 0x80000000/−1 → 0x80000000.
- `reset` pulsed 10 cycles into a DIV → `busy`/`out_valid` 0 immediately, and no `out_valid` within 40 cycles after release. With the macro off, MUL → `illegal` 1 after 1 cycle.
